// File: rtl/ins_mem_loader.sv
// Boot loader and address-port arbiter for an asynchronous-read instruction
// memory. It assembles a little-endian byte stream into instruction words,
// writes them to consecutive word addresses, and then hands the address port
// to the CPU PC and releases the CPU from reset.
module ins_mem_loader #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int MEMORY_DEPTH      = 256,
  parameter int PC_WIDTH          = 32,
  parameter int BYTE_WIDTH        = 8,
  parameter int ADDRESS_WIDTH     = $clog2(MEMORY_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         start,
  input  logic [ADDRESS_WIDTH:0]       word_count,
  input  logic [BYTE_WIDTH-1:0]        rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  input  logic [PC_WIDTH-1:0]          pc,
  output logic [PC_WIDTH-1:0]          mem_address,
  output logic                         mem_wr_en,
  output logic [INSTRUCTION_WIDTH-1:0] mem_wr_data,
  output logic                         cpu_rstN,
  output logic                         busy,
  output logic                         done
);

  localparam int BYTES_PER_WORD = INSTRUCTION_WIDTH / BYTE_WIDTH;
  localparam int BYTE_IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [BYTE_IDX_W-1:0]  LAST_SLOT = BYTE_IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDRESS_WIDTH:0] DEPTH_CNT = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]                   state;
  logic [ADDRESS_WIDTH:0]       count;
  logic [ADDRESS_WIDTH-1:0]     word_idx;
  logic [BYTE_IDX_W-1:0]        byte_idx;
  logic [INSTRUCTION_WIDTH-1:0] asm_word;
  logic [INSTRUCTION_WIDTH-1:0] next_word;
  logic                         last_word;
  logic                         accept;

  assign accept    = rx_valid && rx_ready;
  assign last_word = ({1'b0, word_idx} == (count - (ADDRESS_WIDTH + 1)'(1)));

  // The CPU owns the address port only while running; otherwise the loader
  // presents the current word index (which is also the write address).
  assign mem_address = (state == RUN) ? pc : PC_WIDTH'(word_idx);

  // Merge the incoming byte into its slot of the word being assembled.
  always_comb begin
    // NOTE: default assignment first so every path drives next_word and no latch is inferred.
    next_word = asm_word;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (byte_idx == BYTE_IDX_W'(i)) begin
        next_word[i*BYTE_WIDTH +: BYTE_WIDTH] = rx_data;
      end
    end
  end

  // Mode sequencing, byte assembly, write strobe and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state       <= IDLE;
      count       <= '0;
      word_idx    <= '0;
      byte_idx    <= '0;
      asm_word    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      rx_ready    <= 1'b0;
      cpu_rstN    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      case (state)
        LOAD: begin
          if (mem_wr_en && last_word) begin
            // Final word is being written; any byte offered now is dropped.
            state    <= RUN;
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_rstN <= 1'b1;
          end else begin
            if (mem_wr_en) begin
              word_idx <= word_idx + ADDRESS_WIDTH'(1);
            end
            if (accept) begin
              asm_word <= next_word;
              if (byte_idx == LAST_SLOT) begin
                // The completed word moves to the write register, freeing
                // the assembly register for the next word's bytes.
                byte_idx    <= '0;
                mem_wr_data <= next_word;
                mem_wr_en   <= 1'b1;
              end else begin
                byte_idx <= byte_idx + BYTE_IDX_W'(1);
              end
            end
          end
        end
        default: begin
          // IDLE and RUN both honour start; a zero count just runs the CPU.
          if (start) begin
            if (word_count != '0) begin
              state    <= LOAD;
              count    <= (word_count > DEPTH_CNT) ? DEPTH_CNT : word_count;
              word_idx <= '0;
              byte_idx <= '0;
              asm_word <= '0;
              rx_ready <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
              cpu_rstN <= 1'b0;
            end else begin
              state    <= RUN;
              done     <= 1'b1;
              cpu_rstN <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Self-checking bench for ins_mem_loader: a transaction-level model predicts
// every cycle's outputs from the byte stream and control inputs; directed
// sequences plus randomized loads exercise it.
module tb_ins_mem_loader;

  localparam int BPW = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [8:0]  word_count;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] pc;
  logic [31:0] mem_address;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic        cpu_rstN;
  logic        busy;
  logic        done;

  ins_mem_loader dut (
    .clk(clk), .rstN(rstN), .start(start), .word_count(word_count),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .pc(pc),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .cpu_rstN(cpu_rstN), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_LOAD, M_RUN} mode_t;
  mode_t        m_mode = M_IDLE;
  logic [7:0]   m_bytes[$];
  int           m_count, m_written;
  bit           m_pending, was_pending, finish;
  logic [31:0]  m_wr_word;
  bit           model_valid = 0;

  always @(posedge clk) begin
    if (!rstN) begin
      m_mode = M_IDLE; m_bytes.delete(); m_pending = 0; m_written = 0; model_valid = 1;
    end else if (model_valid) begin
      was_pending = m_pending;
      m_pending   = 0;
      finish      = 0;
      if (was_pending) begin
        m_written++;
        finish = (m_written == m_count);
      end
      if (m_mode == M_LOAD) begin
        if (finish) m_mode = M_RUN;
        else if (rx_valid) begin
          m_bytes.push_back(rx_data);
          if (m_bytes.size() == BPW) begin
            m_wr_word = 0;
            for (int i = 0; i < BPW; i++) m_wr_word |= 32'(m_bytes[i]) << (8 * i);
            m_pending = 1;
            m_bytes.delete();
          end
        end
      end else if (start) begin
        if (word_count != 0) begin
          m_mode    = M_LOAD;
          m_count   = (int'(word_count) > 256) ? 256 : int'(word_count);
          m_written = 0;
          m_bytes.delete();
        end else m_mode = M_RUN;
      end
    end
  end

  // ---------------- per-cycle compare and write log ----------------
  logic [31:0] mem_img[256];
  int          n_writes = 0;
  logic [31:0] last_wr_addr, last_wr_data;
  int          bad_addr = 0;

  always @(negedge clk) begin
    if (model_valid) begin
      check("busy",     busy,      m_mode == M_LOAD);
      check("done",     done,      m_mode == M_RUN);
      check("rx_ready", rx_ready,  m_mode == M_LOAD);
      check("cpu_rstN", cpu_rstN,  m_mode == M_RUN);
      check("wr_en",    mem_wr_en, m_pending);
      check("address",  mem_address, (m_mode == M_RUN) ? pc : 32'(m_written));
      if (m_pending) check("wr_data", mem_wr_data, m_wr_word);
      if (mem_wr_en === 1'b1) begin
        n_writes++;
        last_wr_addr = mem_address;
        last_wr_data = mem_wr_data;
        if (mem_address > 32'd255) bad_addr++;
        else mem_img[mem_address[7:0]] = mem_wr_data;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1; word_count = 9'(n);
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin step(); n++; end
    check("reached_run", done, 1'b1);
  endtask

  logic [7:0]  b3[1024];
  logic [7:0]  b2[12];
  logic [31:0] w;
  int          wr0;

  initial begin
    rstN = 1'b0; start = 1'b0; word_count = '0; rx_data = '0; rx_valid = 1'b0; pc = '0;
    step(); step(); step();
    check("reset_cpu_rstN", cpu_rstN, 1'b0);
    check("reset_rx_ready", rx_ready, 1'b0);
    check("reset_wr_en",    mem_wr_en, 1'b0);
    check("reset_wr_data",  mem_wr_data, 32'h0);
    check("reset_busy_done", {busy, done}, 2'b00);
    rstN = 1'b1;
    step();

    // Test 1: single word, back-to-back bytes
    pc = 32'h4;
    pulse_start(1);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
    rx_valid = 1'b1; rx_data = 8'h00; step(); rx_valid = 1'b0;
    check("t1_wr_en",   mem_wr_en, 1'b1);
    check("t1_wr_addr", mem_address, 32'h0);
    check("t1_wr_data", mem_wr_data, 32'h0000_0013);
    step();
    check("t1_done",     done, 1'b1);
    check("t1_cpu_rstN", cpu_rstN, 1'b1);
    check("t1_pc_pass",  mem_address, 32'h4);

    // Test 2: three words, rx_valid toggling every cycle
    wr0 = n_writes;
    pulse_start(3);
    for (int i = 0; i < 12; i++) begin
      b2[i] = 8'($urandom);
      send_byte(b2[i]);
      step();
    end
    wait_done(10);
    check("t2_writes", n_writes - wr0, 3);
    for (int k = 0; k < 3; k++)
      check("t2_word", mem_img[k], {b2[4*k+3], b2[4*k+2], b2[4*k+1], b2[4*k]});

    // Test 3: clamped count, 1024 bytes
    wr0 = n_writes;
    pulse_start(300);
    for (int i = 0; i < 1024; i++) begin
      b3[i] = 8'($urandom);
      rx_valid = 1'b1; rx_data = b3[i]; step();
    end
    rx_valid = 1'b0;
    wait_done(10);
    check("t3_writes", n_writes - wr0, 256);
    check("t3_bad_addr", bad_addr, 0);
    check("t3_last_addr", last_wr_addr, 32'd255);
    check("t3_word0",   mem_img[0],   {b3[3], b3[2], b3[1], b3[0]});
    check("t3_word255", mem_img[255], {b3[1023], b3[1022], b3[1021], b3[1020]});

    // Test 4: reset after 6 bytes of a 2-word load
    pulse_start(2);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    rstN = 1'b0; step();
    check("t4_cpu_rstN", cpu_rstN, 1'b0);
    check("t4_rx_ready", rx_ready, 1'b0);
    check("t4_idle",     {busy, done}, 2'b00);
    rstN = 1'b1; step();
    wr0 = n_writes;
    pulse_start(1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    check("t4_wr_addr", last_wr_addr, 32'h0);
    check("t4_wr_data", last_wr_data, 32'hDDCC_BBAA);
    check("t4_writes",  n_writes - wr0, 1);
    wait_done(10);

    // Test 5: reload from RUN
    pulse_start(1);
    check("t5_cpu_rstN", cpu_rstN, 1'b0);
    check("t5_busy",     busy, 1'b1);
    wr0 = n_writes;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("t5_wr_addr", last_wr_addr, 32'h0);
    check("t5_wr_data", last_wr_data, 32'h4433_2211);
    wait_done(10);
    check("t5_writes", n_writes - wr0, 1);

    // Test 6: zero count from IDLE
    rstN = 1'b0; step(); rstN = 1'b1; step();
    wr0 = n_writes;
    pulse_start(0);
    check("t6_done",     done, 1'b1);
    check("t6_cpu_rstN", cpu_rstN, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    check("t6_writes", n_writes - wr0, 0);

    // Randomized loads: gaps, ignored starts, dropped trailing bytes, moving pc
    for (int r = 0; r < 8; r++) begin
      pulse_start(int'($urandom_range(0, 5)));
      for (int c = 0; c < 300 && done !== 1'b1; c++) begin
        rx_valid   = ($urandom_range(0, 3) != 0);
        rx_data    = 8'($urandom);
        start      = ($urandom_range(0, 7) == 0);
        word_count = 9'($urandom_range(0, 9));
        pc         = $urandom;
        step();
      end
      start = 1'b0; rx_valid = 1'b0;
      wait_done(5);
      pc = $urandom; step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
